// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared RV32I fetch definitions and helpers
package inst_fetch_unit_pkg;

    localparam int          XLEN            = 32;
    localparam logic [31:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] RV32I_NOP       = 32'h0000_0013;

    // One buffered fetch: PC in the upper half, instruction word in the lower half
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & INST_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, used for fetch data and in-flight PCs
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue and wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch: PC, imem request/response, prefetch FIFO, redirect
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] INST,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          credit_ok;
    logic          accept;
    logic          rsp_ok;
    logic          rsp_keep;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_head;
    fetch_entry_t  head_entry;

    logic          pcq_full, pcq_empty;
    logic [CW-1:0] pcq_count;
    logic [31:0]   pcq_head;

    // Credit uses registered counts only, so a pop this cycle frees nothing until next cycle
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored entirely
    assign rsp_ok   = imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep = rsp_ok && !redirect_valid && (drop_q == '0);

    // PCs of outstanding fetches, popped in order as responses (kept or dropped) return
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (pc_q),
        .pop       (rsp_ok),
        .flush     (1'b0),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count),
        .head      (pcq_head)
    );

    // Prefetch buffer of {pc, inst}; redirect flushes it and masks any pop that cycle
    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (inst_valid && inst_ready && !redirect_valid),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign head_entry = fetch_entry_t'(fifo_head);
    assign inst_valid = !fifo_empty;
    assign INST       = inst_valid ? head_entry.inst : 32'h0;
    assign inst_pc    = inst_valid ? head_entry.pc   : 32'h0;

    // Next PC and counters; on redirect every fetch still outstanding becomes stale
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d       = align_pc(redirect_pc);
            inflight_d = inflight_q - CW'(rsp_ok);
            drop_d     = inflight_q - CW'(rsp_ok);
        end else begin
            if (accept) begin
                pc_d = pc_q + PC_STEP;
            end
            inflight_d = inflight_q + CW'(accept) - CW'(rsp_ok);
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // PC and outstanding/drop counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    a_inflight_max: assert property (@(posedge clk) disable iff (rst)
        inflight_q <= CW'(FIFO_DEPTH));
    a_drop_max: assert property (@(posedge clk) disable iff (rst)
        drop_q <= inflight_q);
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && fifo_full));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(accept && pcq_full));
    a_pcq_tracks: assert property (@(posedge clk) disable iff (rst)
        (pcq_count == inflight_q) && (pcq_empty == (inflight_q == '0)));

endmodule
